// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and
// multi-cycle data-memory freeze, with a saturating stall counter and sticky timeout.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    input  logic             mem_done,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_timeout,
    output logic [1:0]       dbg_state
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic pc_w, ifid_w, idex_w, exmem_w, bubble, ifid_fl, idex_fl;
    logic load_use;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        stall_d       = stall_q;
        pc_w          = 1'b1;
        ifid_w        = 1'b1;
        idex_w        = 1'b1;
        exmem_w       = 1'b1;
        bubble        = 1'b0;
        ifid_fl       = 1'b0;
        idex_fl       = 1'b0;

        case (state_q)
            ST_RUN: begin
                // mem_busy outranks mem_done here; done only matters once waiting
                if (mem_busy) begin
                    pc_w       = 1'b0;
                    ifid_w     = 1'b0;
                    idex_w     = 1'b0;
                    exmem_w    = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = ST_MEM_WAIT;
                end else if (ex_branch_taken) begin
                    ifid_fl = 1'b1;
                    idex_fl = 1'b1;
                    state_d = ST_FLUSH;
                end else if (load_use) begin
                    pc_w    = 1'b0;
                    ifid_w  = 1'b0;
                    bubble  = 1'b1;
                    state_d = ST_LU_STALL;
                end
            end
            ST_LU_STALL, ST_FLUSH: begin
                if (mem_busy) begin
                    pc_w       = 1'b0;
                    ifid_w     = 1'b0;
                    idex_w     = 1'b0;
                    exmem_w    = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_done) begin
                    pc_w    = 1'b0;
                    ifid_w  = 1'b0;
                    idex_w  = 1'b0;
                    exmem_w = 1'b0;
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    // flag lands on the edge that completes the MEM_TIMEOUT-th wait cycle
                    if (wait_cnt_q >= WAIT_LAST) begin
                        mem_timeout_d = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (!pc_w && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_q       <= stall_d;
        end
    end

    // All enables drop immediately while reset is held, independent of inputs
    assign pc_write    = rst_n & pc_w;
    assign ifid_write  = rst_n & ifid_w;
    assign idex_write  = rst_n & idex_w;
    assign exmem_write = rst_n & exmem_w;
    assign idex_bubble = rst_n & bubble;
    assign ifid_flush  = rst_n & ifid_fl;
    assign idex_flush  = rst_n & idex_fl;
    assign stall_cnt   = stall_q;
    assign mem_timeout = mem_timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, masking, branch flush, memory freeze,
// timeout, counter saturation and asynchronous reset.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int MEM_TIMEOUT = 4;

    // {pc_write, ifid_write, idex_write, exmem_write, idex_bubble, ifid_flush, idex_flush}
    localparam logic [6:0] O_DEF = 7'b1111000;
    localparam logic [6:0] O_FRZ = 7'b0000000;
    localparam logic [6:0] O_LU  = 7'b0011100;
    localparam logic [6:0] O_BR  = 7'b1111011;
    localparam logic [6:0] O_RST = 7'b0000000;

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_LU  = 2'd1;
    localparam logic [1:0] S_FL  = 2'd2;
    localparam logic [1:0] S_MW  = 2'd3;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic id_uses_rt, ex_mem_read, ex_branch_taken, mem_busy, mem_done;
    logic pc_write, ifid_write, idex_write, exmem_write;
    logic idex_bubble, ifid_flush, idex_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic mem_timeout;
    logic [1:0] dbg_state;
    logic [6:0] outs;

    int checks = 0;
    int errors = 0;

    assign outs = {pc_write, ifid_write, idex_write, exmem_write, idex_bubble, ifid_flush, idex_flush};

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .mem_done(mem_done),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .stall_cnt(stall_cnt), .mem_timeout(mem_timeout),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic clr_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
        mem_busy = 1'b0; mem_done = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rt, input logic [4:0] rs);
        ex_mem_read = 1'b1; ex_rt = rt; id_rs = rs;
    endtask

    // Each scenario task starts 1 ns after a rising edge, drives, samples at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr_inputs();
        mem_busy = 1'b1; ex_branch_taken = 1'b1;
        set_load_use(5'd5, 5'd5);
        #2;
        checks++; if (outs !== O_RST) begin errors++; $display("FAIL reset_outs: got %b expected %b", outs, O_RST); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (outs !== O_RST) begin errors++; $display("FAIL reset_outs_held: got %b expected %b", outs, O_RST); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); end
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", mem_timeout); end
        checks++; if (dbg_state !== S_RUN) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_RUN); end
        rst_n = 1'b1;
        clr_inputs();
        next_cycle();
        @(negedge clk);
        checks++; if (outs !== O_DEF) begin errors++; $display("FAIL post_reset_outs: got %b expected %b", outs, O_DEF); end
        next_cycle();
    endtask

    task automatic test_load_use();
        set_load_use(5'd5, 5'd5);
        @(negedge clk);
        checks++; if (outs !== O_LU) begin errors++; $display("FAIL lu_rs_outs: got %b expected %b", outs, O_LU); end
        next_cycle();
        @(negedge clk);
        checks++; if (outs !== O_DEF) begin errors++; $display("FAIL lu_masked_outs: got %b expected %b", outs, O_DEF); end
        checks++; if (dbg_state !== S_LU) begin errors++; $display("FAIL lu_state: got %0d expected %0d", dbg_state, S_LU); end
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt); end
        next_cycle();
        clr_inputs();
        ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd2; id_uses_rt = 1'b1;
        @(negedge clk);
        checks++; if (outs !== O_LU) begin errors++; $display("FAIL lu_rt_outs: got %b expected %b", outs, O_LU); end
        next_cycle();
        clr_inputs();
        @(negedge clk);
        checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL lu_rt_cnt: got %0d expected 2", stall_cnt); end
        next_cycle();
        @(negedge clk);
        checks++; if (dbg_state !== S_RUN) begin errors++; $display("FAIL lu_back_run: got %0d expected %0d", dbg_state, S_RUN); end
        next_cycle();
    endtask

    task automatic test_masking();
        set_load_use(5'd0, 5'd0);
        @(negedge clk);
        checks++; if (outs !== O_DEF) begin errors++; $display("FAIL mask_r0: got %b expected %b", outs, O_DEF); end
        next_cycle();
        clr_inputs();
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
        @(negedge clk);
        checks++; if (outs !== O_DEF) begin errors++; $display("FAIL mask_rt_unused: got %b expected %b", outs, O_DEF); end
        next_cycle();
        clr_inputs();
        ex_mem_read = 1'b0; ex_rt = 5'd4; id_rs = 5'd4;
        @(negedge clk);
        checks++; if (outs !== O_DEF) begin errors++; $display("FAIL mask_no_load: got %b expected %b", outs, O_DEF); end
        next_cycle();
        clr_inputs();
        @(negedge clk);
        checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL mask_cnt: got %0d expected 2", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_branch();
        set_load_use(5'd5, 5'd5);
        ex_branch_taken = 1'b1;
        @(negedge clk);
        checks++; if (outs !== O_BR) begin errors++; $display("FAIL br_outs: got %b expected %b", outs, O_BR); end
        next_cycle();
        @(negedge clk);
        checks++; if (outs !== O_DEF) begin errors++; $display("FAIL br_after_outs: got %b expected %b", outs, O_DEF); end
        checks++; if (dbg_state !== S_FL) begin errors++; $display("FAIL br_state: got %0d expected %0d", dbg_state, S_FL); end
        next_cycle();
        clr_inputs();
        @(negedge clk);
        checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL br_cnt: got %0d expected 2", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_mem_stall();
        mem_busy = 1'b1;
        @(negedge clk);
        checks++; if (outs !== O_FRZ) begin errors++; $display("FAIL mem_first_outs: got %b expected %b", outs, O_FRZ); end
        next_cycle();
        mem_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ex_branch_taken = (i == 1);
            set_load_use(5'd6, (i == 2) ? 5'd6 : 5'd1);
            @(negedge clk);
            checks++; if (outs !== O_FRZ) begin errors++; $display("FAIL mem_wait_outs[%0d]: got %b expected %b", i, outs, O_FRZ); end
            checks++; if (dbg_state !== S_MW) begin errors++; $display("FAIL mem_wait_state[%0d]: got %0d expected %0d", i, dbg_state, S_MW); end
            next_cycle();
        end
        clr_inputs();
        mem_done = 1'b1;
        @(negedge clk);
        checks++; if (outs !== O_DEF) begin errors++; $display("FAIL mem_done_outs: got %b expected %b", outs, O_DEF); end
        next_cycle();
        clr_inputs();
        @(negedge clk);
        checks++; if (dbg_state !== S_RUN) begin errors++; $display("FAIL mem_back_run: got %0d expected %0d", dbg_state, S_RUN); end
        checks++; if (stall_cnt !== 4'd6) begin errors++; $display("FAIL mem_cnt: got %0d expected 6", stall_cnt); end
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL mem_no_timeout: got %b expected 0", mem_timeout); end
        next_cycle();
    endtask

    task automatic test_busy_and_done();
        mem_busy = 1'b1; mem_done = 1'b1;
        @(negedge clk);
        checks++; if (outs !== O_FRZ) begin errors++; $display("FAIL bd_outs: got %b expected %b", outs, O_FRZ); end
        next_cycle();
        mem_busy = 1'b0;
        @(negedge clk);
        checks++; if (dbg_state !== S_MW) begin errors++; $display("FAIL bd_state: got %0d expected %0d", dbg_state, S_MW); end
        checks++; if (outs !== O_DEF) begin errors++; $display("FAIL bd_done_outs: got %b expected %b", outs, O_DEF); end
        next_cycle();
        clr_inputs();
        set_load_use(5'd3, 5'd3);
        @(negedge clk);
        checks++; if (outs !== O_LU) begin errors++; $display("FAIL b2b_lu_outs: got %b expected %b", outs, O_LU); end
        next_cycle();
        mem_busy = 1'b1;
        @(negedge clk);
        checks++; if (outs !== O_FRZ) begin errors++; $display("FAIL lu_busy_outs: got %b expected %b", outs, O_FRZ); end
        next_cycle();
        clr_inputs();
        mem_done = 1'b1;
        @(negedge clk);
        checks++; if (dbg_state !== S_MW) begin errors++; $display("FAIL lu_busy_state: got %0d expected %0d", dbg_state, S_MW); end
        next_cycle();
        clr_inputs();
        @(negedge clk);
        checks++; if (stall_cnt !== 4'd9) begin errors++; $display("FAIL bd_cnt: got %0d expected 9", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_timeout();
        mem_busy = 1'b1;
        next_cycle();
        mem_busy = 1'b0;
        for (int w = 1; w <= 7; w++) begin
            @(negedge clk);
            if (w == 4) begin
                checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0", mem_timeout); end
            end
            if (w == 5) begin
                checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_set: got %b expected 1", mem_timeout); end
            end
            if (w == 7) begin
                checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL cnt_sat: got %0d expected 15", stall_cnt); end
                checks++; if (dbg_state !== S_MW) begin errors++; $display("FAIL to_state: got %0d expected %0d", dbg_state, S_MW); end
            end
            next_cycle();
        end
        mem_done = 1'b1;
        @(negedge clk);
        checks++; if (outs !== O_DEF) begin errors++; $display("FAIL to_done_outs: got %b expected %b", outs, O_DEF); end
        next_cycle();
        clr_inputs();
        set_load_use(5'd8, 5'd8);
        @(negedge clk);
        checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", mem_timeout); end
        next_cycle();
        clr_inputs();
        @(negedge clk);
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL cnt_no_wrap: got %0d expected 15", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        mem_busy = 1'b1;
        next_cycle();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (outs !== O_RST) begin errors++; $display("FAIL rst_mw_outs: got %b expected %b", outs, O_RST); end
        checks++; if (dbg_state !== S_RUN) begin errors++; $display("FAIL rst_mw_state: got %0d expected %0d", dbg_state, S_RUN); end
        checks++; if ({mem_timeout, stall_cnt} !== 5'd0) begin errors++; $display("FAIL rst_mw_regs: got %b expected 00000", {mem_timeout, stall_cnt}); end
        @(negedge clk);
        rst_n = 1'b1;
        clr_inputs();
        @(negedge clk);
        checks++; if (outs !== O_DEF) begin errors++; $display("FAIL rst_release_outs: got %b expected %b", outs, O_DEF); end
        checks++; if (dbg_state !== S_RUN) begin errors++; $display("FAIL rst_release_state: got %0d expected %0d", dbg_state, S_RUN); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_release_cnt: got %0d expected 0", stall_cnt); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_masking();
        test_branch();
        test_mem_stall();
        test_busy_and_done();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max consecutive MEM_WAIT cycles before timeout flag.
REQ-002 SHALL have parameter CNT_W, default 16, width of stall counter.
REQ-003 SHALL have ports (name, direction, width, meaning):
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  asynchronous, active-low reset
  id_rs  in  5  rs field of instruction in ID
  id_rt  in  5  rt field of instruction in ID
  id_uses_rt  in  1  ID instruction reads rt as a source
  ex_mem_read  in  1  instruction in EX is a load (MemRead)
  ex_rt  in  5  destination rt of instruction in EX
  ex_branch_taken  in  1  branch resolved taken in EX this cycle
  mem_busy  in  1  data memory requests a multi-cycle stall
  mem_done  in  1  data memory access completes this cycle
  pc_write  out  1  PC register load enable
  ifid_write  out  1  IF/ID register load enable
  idex_write  out  1  ID/EX register load enable
  exmem_write  out  1  EX/MEM register load enable
  idex_bubble  out  1  insert NOP control word into ID/EX
  ifid_flush  out  1  clear IF/ID to NOP
  idex_flush  out  1  clear ID/EX to NOP
  stall_cnt  out  CNT_W  total stall cycles since reset
  mem_timeout  out  1  sticky: MEM_WAIT exceeded MEM_TIMEOUT

Function
REQ-004 SHALL implement FSM states RUN, LU_STALL, FLUSH, MEM_WAIT; control outputs combinational from state and inputs.
REQ-005 Default outputs (no event): pc_write=ifid_write=idex_write=exmem_write=1, idex_bubble=ifid_flush=idex_flush=0.
REQ-006 Load-use hazard = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
REQ-007 Event priority in RUN: mem_busy > ex_branch_taken > load-use.
REQ-008 RUN + mem_busy: freeze (pc_write=ifid_write=idex_write=exmem_write=0, no flush/bubble); next MEM_WAIT.
REQ-009 RUN + ex_branch_taken (no mem_busy): ifid_flush=1, idex_flush=1, pc_write=1; next FLUSH.
REQ-010 RUN + load-use (no higher event): pc_write=0, ifid_write=0, idex_bubble=1; next LU_STALL.
REQ-011 RUN, no event: defaults; stay RUN.
REQ-012 LU_STALL and FLUSH: one cycle each, load-use detection masked, ex_branch_taken ignored, mem_busy handled as in RUN (REQ-008); otherwise defaults, next RUN.
REQ-013 MEM_WAIT, mem_done=0: freeze held; stay. mem_done=1: defaults that cycle, next RUN. mem_busy, ex_branch_taken, load-use ignored in MEM_WAIT.
REQ-014 Internal wait counter SHALL clear on entering MEM_WAIT and increment each MEM_WAIT cycle with mem_done=0; when it reaches MEM_TIMEOUT, mem_timeout SHALL set next edge and hold until reset; FSM stays in MEM_WAIT.
REQ-015 stall_cnt SHALL increment by 1 for each cycle with pc_write=0; saturates at 2^CNT_W-1, no wrap.
REQ-016 Simultaneous mem_busy and mem_done in RUN: mem_done ignored, REQ-008 applies.

Reset
REQ-017 rst_n=0 SHALL asynchronously force state=RUN, stall_cnt=0, wait counter=0, mem_timeout=0.
REQ-018 While rst_n=0, pc_write=ifid_write=idex_write=exmem_write=0 and idex_bubble=ifid_flush=idex_flush=0, regardless of inputs.
REQ-019 Reset mid-MEM_WAIT or mid-stall SHALL abandon the operation; first cycle after release is RUN with defaults.

Verification
REQ-020 Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 in RUN -> pc_write=0, ifid_write=0, idex_bubble=1 one cycle, then defaults; stall_cnt=1.
REQ-021 Masking: ex_rt=0 with id_rs=0, or id_rt match with id_uses_rt=0 -> no stall; stall_cnt unchanged.
REQ-022 Branch: ex_branch_taken=1 with concurrent load-use -> ifid_flush=idex_flush=1, pc_write=1, no bubble; next cycle defaults even if load-use still true.
REQ-023 Memory stall: mem_busy=1 one cycle, mem_done after 3 further cycles -> freeze for 4 cycles, defaults on mem_done cycle; stall_cnt=4.
REQ-024 Timeout: MEM_TIMEOUT=4, mem_busy then mem_done held 0 -> mem_timeout=1 after 4 wait cycles, stays 1 after mem_done; cleared only by rst_n=0.
REQ-025 Reset in MEM_WAIT: rst_n low asynchronously -> all enables 0 immediately; after release state RUN, stall_cnt=0, defaults.
